dpram_stream_reader: RTL and testbench
======================================

Name: dpram_stream_reader

Overview:
- Read-side sequencer placed directly upstream of the 4096x60 dual-port RAM's port B.
- Given a start pulse, base address and length, it issues sequential reads and absorbs the RAM's one-cycle registered read latency.
- Delivers the words on a valid/ready stream with a last marker; a 2-entry skid FIFO provides full-throughput backpressure.
- Consumers are the compute stages that drain tiles out of the buffer RAM.

Parameters:
- AWIDTH, 12, RAM address width; the RAM holds 2^AWIDTH words.
- DWIDTH, 60, RAM word width.
- LWIDTH, 13, length field width (AWIDTH+1, so a full 4096-word transfer is expressible).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  AWIDTH  first word address; captured with start.
- length  input  LWIDTH  word count, 0..4096; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last word handshakes.
- ram_addr  output  AWIDTH  to RAM address_b.
- ram_wren  output  1  to RAM wren_b; constant 0.
- ram_rd_data  input  DWIDTH  from RAM out_b.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DWIDTH  stream payload.
- out_last  output  1  high with the final word of a transfer.
- stall_cycles  output  32  backpressure counter (see Optional Feature).

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, out_valid=0, out_last=0, ram_addr=0, FIFO empty, counters 0, stall_cycles=0. ram_wren is always 0.
- States:
  - IDLE: start=1 with length>0 -> ISSUE. start=1 with length=0 -> DONE (no RAM read). start while not IDLE is ignored.
  - ISSUE: one read per cycle while credit is available and issued<length. When issued==length -> DRAIN.
  - DRAIN: waits until received==length, the FIFO is empty and the last word has handshaked -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. busy=0 in IDLE and DONE.
- Read timing: the read address is presented on ram_addr in cycle N. The RAM registers data at edge N+1. A pending flag pushes ram_rd_data into the FIFO in cycle N+1.
- Credit rule: issue in a cycle only if (FIFO occupancy + pending) < 2, counting a same-cycle pop as freeing a slot. The FIFO therefore never overflows.
- Throughput: 1 word/cycle with out_ready held high. First out_valid appears 2 cycles after the start edge.
- Address: starts at base_addr, incremented mod 2^AWIDTH, so 4095 wraps to 0. length=4096 reads every word exactly once.
- Stream rules:
  - out_data/out_valid/out_last are driven from the FIFO head. They stay stable while out_valid && !out_ready.
  - out_last=1 only on the word numbered length-1.
- Simultaneous push and pop on the full FIFO is not possible (credit rule). Push and pop together on occupancy 1 keeps occupancy at 1.
- Asynchronous reset mid-transfer aborts immediately. Outstanding RAM data is discarded and no done pulse is generated.

Optional Feature:
- Macro: DPRAM_STREAM_STALL_CNT_EN.
- Defined: stall_cycles increments each cycle with out_valid=1 && out_ready=0, saturating at 2^32-1. It clears on an accepted start.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package dpram_rd_pkg holds:
  - AWIDTH/DWIDTH/LWIDTH defaults.
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
  - Constant SKID_DEPTH=2.
- Sub-module rd_skid_fifo: 2-entry DWIDTH+1 (data plus last) FIFO with push/pop/occupancy. The top level holds the FSM, counters and credit logic.

Test Plan:
- Base=0x010, length=4, out_ready=1 -> words from addresses 0x010..0x013 on 4 consecutive cycles starting start+2; out_last on the 4th; done pulse once.
- Base=0xFFE, length=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- Length=0 -> no ram_addr change, no out_valid; done 1 cycle after start.
- Length=8 with out_ready toggling 1,0,0,1 repeating -> all 8 words in order, none lost or duplicated; out_data stable while stalled; stall_cycles=8 with the macro defined, 0 without.
- Length=4096, base=0x800, out_ready=1 -> 4096 words, every address once, done after the last handshake.
- resetn asserted mid-transfer at word 3 of 10, then a new start with length=2 -> outputs 0 during reset; new transfer clean with no stale data.

Source files
------------

// File: rtl/dpram_stream_reader_pkg.sv
// dpram_rd_pkg: shared widths, FSM states and skid depth for the RAM stream reader
package dpram_rd_pkg;
  localparam int DEF_AWIDTH = 12;
  localparam int DEF_DWIDTH = 60;
  localparam int DEF_LWIDTH = 13;
  localparam int SKID_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/dpram_stream_reader_if.sv
// dpram_stream_reader_if: valid/ready word stream with last marker
interface dpram_stream_reader_if #(parameter int DWIDTH = 60);
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;
  modport master(output out_valid, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry skid FIFO holding {last, data} for the stream reader
module rd_skid_fifo import dpram_rd_pkg::*; #(parameter int W = DEF_DWIDTH + 1) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [SKID_DEPTH];
  logic         wp, rp;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp  <= wp ^ push;
      rp  <= rp ^ pop;
      occ <= occ + 2'(push) - 2'(pop);
    end
  assign dout  = mem[rp];
  assign valid = occ != 2'd0;
endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: sequential RAM port-B reader onto a stream; DPRAM_STREAM_STALL_CNT_EN enables stall_cycles
module dpram_stream_reader import dpram_rd_pkg::*; #(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [LWIDTH-1:0]     length,
  output logic                  busy,
  output logic                  done,
  output logic [AWIDTH-1:0]     ram_addr,
  output logic                  ram_wren,
  input  logic [DWIDTH-1:0]     ram_rd_data,
  output logic [31:0]           stall_cycles,
  dpram_stream_reader_if.master s
);
  state_t            st, nst;
  logic [AWIDTH-1:0] addr;
  logic [LWIDTH-1:0] len_q, issued;
  logic              pend, pend_last, accept, pop, issue, v;
  logic [1:0]        occ;
  logic [DWIDTH:0]   head;
  assign accept = st == IDLE && start;
  assign pop    = v && s.out_ready;
  // a word in flight from the RAM already owns a FIFO slot
  assign issue  = st == ISSUE && (3'(occ) + 3'(pend) - 3'(pop)) < 3'(SKID_DEPTH);
  always_comb begin
    nst = st;
    nst = st == IDLE  ? (start ? (length == '0 ? DONE : ISSUE) : IDLE)
        : st == ISSUE ? (issue && issued == len_q - 1'b1 ? DRAIN : ISSUE)
        : st == DRAIN ? (pop && s.out_last ? DONE : DRAIN)
        : IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st        <= IDLE;
      addr      <= '0;
      len_q     <= '0;
      issued    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      st        <= nst;
      pend      <= issue;
      pend_last <= issue && issued == len_q - 1'b1;
      if (accept && length != '0) begin
        addr   <= base_addr;
        len_q  <= length;
        issued <= '0;
      end else if (issue) begin
        addr   <= addr + 1'b1;
        issued <= issued + 1'b1;
      end
    end
  rd_skid_fifo #(.W(DWIDTH + 1)) u_fifo (
    .clk(clk), .resetn(resetn), .push(pend), .pop(pop),
    .din({pend_last, ram_rd_data}), .dout(head), .valid(v), .occ(occ)
  );
  assign s.out_valid = v;
  assign s.out_data  = head[DWIDTH-1:0];
  assign s.out_last  = v & head[DWIDTH];
  assign ram_addr    = addr;
  assign ram_wren    = 1'b0;
  assign busy        = st == ISSUE || st == DRAIN;
  assign done        = st == DONE;
`ifdef DPRAM_STREAM_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) stall_q <= '0;
    else if (accept) stall_q <= '0;
    else if (v && !s.out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: scoreboard bench with a registered-read RAM model
module tb_dpram_stream_reader;
  logic        clk = 1'b0;
  logic        resetn, start, busy, done, ram_wren;
  logic [11:0] base_addr, ram_addr;
  logic [12:0] length;
  logic [59:0] ram_rd_data;
  logic [31:0] stall_cycles;
  dpram_stream_reader_if #(.DWIDTH(60)) s();
  dpram_stream_reader dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_rd_data(ram_rd_data), .stall_cycles(stall_cycles), .s(s)
  );
`ifdef DPRAM_STREAM_STALL_CNT_EN
  localparam int STALL_EXP = 8;
`else
  localparam int STALL_EXP = 0;
`endif
  always #5 clk = ~clk;
  function automatic logic [59:0] pat(logic [11:0] a);
    return {36'h5A5A5A5A5, ~a, a};
  endfunction
  always @(posedge clk) ram_rd_data <= pat(ram_addr);
  int          nvec = 0, nerr = 0, done_cnt = 0, hs_cnt = 0;
  bit          vseen, hold_v;
  logic [60:0] hold_d;
  logic [60:0] exp_q[$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (!resetn) hold_v = 1'b0;
    else begin
      if (done) done_cnt++;
      if (s.out_valid) vseen = 1'b1;
      if (hold_v) chk("stable", {s.out_last, s.out_data}, hold_d);
      if (s.out_valid && s.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious: got word %0h with nothing expected", s.out_data);
        end else begin
          logic [60:0] e;
          e = exp_q.pop_front();
          chk("data", s.out_data, e[59:0]);
          chk("last", s.out_last, e[60]);
        end
      end
      hold_v = s.out_valid && !s.out_ready;
      hold_d = {s.out_last, s.out_data};
    end
  task automatic run(input logic [11:0] b, input int len, input bit stall, input int abort, input int sexp);
    logic [11:0] a0;
    int t;
    for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pat(b + 12'(i))});
    a0 = ram_addr;
    start = 1'b1;
    base_addr = b;
    length = 13'(len);
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    vseen = 1'b0;
    hs_cnt = 0;
    t = 0;
    s.out_ready = stall ? 1'b0 : 1'b1;
    chk("busy_start", busy, len > 0);
    if (len == 0) chk("done_len0", done, 1);
    while (!done && t < 5000 && !(abort > 0 && hs_cnt >= abort)) begin
      @(posedge clk); #1;
      t++;
      s.out_ready = stall ? (t % 4 == 1 || t % 4 == 2) : 1'b1;
      if (len > 0 && t == 1) chk("valid_c1", s.out_valid, 0);
      if (len > 0 && t == 2) chk("valid_c2", s.out_valid, 1);
    end
    if (t >= 5000) begin
      nvec++;
      nerr++;
      $display("FAIL timeout: no done after %0d cycles, expected within 5000", t);
    end
    if (abort == 0) begin
      chk("busy_done", busy, 0);
      chk("stall", stall_cycles, sexp);
      @(posedge clk); #1;
      s.out_ready = 1'b1;
      chk("done_pulse", done, 0);
      @(negedge clk);
      chk("done_cnt", done_cnt, 1);
      chk("drained", exp_q.size(), 0);
      if (len == 0) begin
        chk("addr_len0", ram_addr, a0);
        chk("valid_len0", vseen, 0);
      end
    end
  endtask
  initial begin
    resetn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    s.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", s.out_valid, 0);
    chk("rst_last", s.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("wren", ram_wren, 0);
    resetn = 1'b1;
    @(negedge clk);
    run(12'h010, 4, 1'b0, 0, 0);
    run(12'hFFE, 4, 1'b0, 0, 0);
    run(12'h123, 0, 1'b0, 0, 0);
    run(12'h040, 8, 1'b1, 0, STALL_EXP);
    run(12'h800, 4096, 1'b0, 0, 0);
    run(12'h100, 10, 1'b0, 3, 0);
    resetn = 1'b0;
    #1;
    chk("abort_valid", s.out_valid, 0);
    chk("abort_last", s.out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_stall", stall_cycles, 0);
    exp_q.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run(12'h020, 2, 1'b0, 0, 0);
    chk("wren_end", ram_wren, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
